dma_icb_rd_master: RTL and testbench
====================================

DMA_ICB_RD_MASTER -- requirements
Module: dma_icb_rd_master

Parameters
REQ-001 SHALL have parameter DW, default `ICB_WIDTH (32), meaning the ICB address/data width.
REQ-002 SHALL have parameter LW, default 16, meaning the width of the transfer length in words.
REQ-003 SHALL have parameter DEPTH, default 4, meaning read-data FIFO depth and maximum outstanding read credits (power of 2).

Interface
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start_i  in  1  one-cycle transfer request; sampled only in IDLE.
REQ-007 src_addr_i  in  DW  word-aligned start address, captured with start_i.
REQ-008 len_i  in  LW  transfer length in words, captured with start_i.
REQ-009 busy_o  out  1  high while not IDLE.
REQ-010 done_o  out  1  one-cycle completion pulse.
REQ-011 err_o  out  1  sticky: any response error in current/last transfer.
REQ-012 icb_cmd_valid_o  out  1  ICB command valid.
REQ-013 icb_cmd_ready_i  in  1  ICB command ready.
REQ-014 icb_cmd_addr_o  out  DW  command address.
REQ-015 icb_cmd_read_o  out  1  tied 1.
REQ-016 icb_cmd_wdata_o  out  DW  tied 0.
REQ-017 icb_cmd_wmask_o  out  DW/8  tied 0.
REQ-018 icb_rsp_valid_i  in  1  ICB response valid.
REQ-019 icb_rsp_ready_o  out  1  ICB response ready.
REQ-020 icb_rsp_rdata_i  in  DW  response read data.
REQ-021 icb_rsp_err_i  in  1  response error flag.
REQ-022 data_valid_o  out  1  read-data stream valid (FIFO not empty).
REQ-023 data_ready_i  in  1  downstream consumer ready.
REQ-024 data_o  out  DW  FIFO head word.

Function
REQ-025 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-026 IDLE + start_i, len_i!=0: capture addr/len, clear err_o, zero cmd_cnt/rsp_cnt, go RUN next cycle.
REQ-027 IDLE + start_i, len_i==0: stay IDLE, assert done_o the following cycle, issue no command, clear err_o.
REQ-028 start_i outside IDLE SHALL be ignored.
REQ-029 RUN: icb_cmd_valid_o = (cmd_cnt < len) AND (outstanding + fifo_count < DEPTH); outstanding = cmd_cnt - rsp_cnt.
REQ-030 Once asserted, icb_cmd_valid_o and icb_cmd_addr_o SHALL hold stable until icb_cmd_ready_i; valid never drops without a handshake.
REQ-031 Each command handshake: cmd_cnt+1; address +DW/8, wrapping modulo 2^DW.
REQ-032 Handshake of the last command (cmd_cnt reaches len) SHALL move RUN -> DRAIN.
REQ-033 icb_rsp_ready_o SHALL be 1 in all states after reset; credit rule REQ-029 guarantees FIFO space.
REQ-034 Each response handshake SHALL push icb_rsp_rdata_i into the FIFO (also when err) and increment rsp_cnt; icb_rsp_err_i=1 sets err_o.
REQ-035 Responses arrive in command order; at most DEPTH commands outstanding.
REQ-036 FIFO push and pop in the same cycle SHALL keep count unchanged; pop when data_valid_o & data_ready_i.
REQ-037 DRAIN -> IDLE when rsp_cnt==len and FIFO empty; done_o pulses in the cycle IDLE is entered.
REQ-038 Response received in IDLE (spurious) SHALL be accepted and dropped, not pushed.
REQ-039 Minimum latency: start_i at cycle 0 -> first icb_cmd_valid_o at cycle 1.

Reset
REQ-040 On rst_n low, immediately: state IDLE, busy_o=0, done_o=0, err_o=0, icb_cmd_valid_o=0, data_valid_o=0, counters and FIFO pointers 0, icb_cmd_addr_o=0.
REQ-041 Reset mid-transfer SHALL abandon the transfer and discard FIFO contents; no done_o.

Verification
REQ-042 start, addr=0x1000, len=3, cmd/rsp always ready, data_ready=1 -> cmds at 0x1000/0x1004/0x1008, 3 words out in order, one done_o, err_o=0.
REQ-043 len=8, data_ready_i=0, immediate responses -> exactly 4 commands accepted, then icb_cmd_valid_o stalls; releasing data_ready completes 8 words.
REQ-044 addr=0xFFFFFFF8, len=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-045 len=4, second response icb_rsp_err_i=1 -> 4 words still delivered, err_o=1 through done_o and until next start.
REQ-046 len=0 -> no command, done_o one cycle later; start_i during RUN ignored, cmd count unchanged.
REQ-047 rst_n low after 2 of 6 commands -> all outputs at reset values same cycle; new start len=1 then completes normally.

Source files
------------

// File: rtl/dma_icb_rd_master_if.sv
// ---------------------------------------------------------------------------
// dma_icb_rd_master_if
// ICB (command/response) bus bundle between a read master and a slave.
//   icb_cmd_valid_o / icb_cmd_ready_i : command handshake (master -> slave)
//   icb_cmd_addr_o                    : command address
//   icb_cmd_read_o                    : read strobe (always 1 for this master)
//   icb_cmd_wdata_o / icb_cmd_wmask_o : write data / byte mask (unused, 0)
//   icb_rsp_valid_i / icb_rsp_ready_o : response handshake (slave -> master)
//   icb_rsp_rdata_i / icb_rsp_err_i   : response read data / error flag
// Suffixes are relative to the master side.
// ---------------------------------------------------------------------------
`ifndef ICB_WIDTH
`define ICB_WIDTH 32
`endif

interface dma_icb_rd_master_if #(
    parameter int DW = `ICB_WIDTH
);
    logic            icb_cmd_valid_o;
    logic            icb_cmd_ready_i;
    logic [DW-1:0]   icb_cmd_addr_o;
    logic            icb_cmd_read_o;
    logic [DW-1:0]   icb_cmd_wdata_o;
    logic [DW/8-1:0] icb_cmd_wmask_o;
    logic            icb_rsp_valid_i;
    logic            icb_rsp_ready_o;
    logic [DW-1:0]   icb_rsp_rdata_i;
    logic            icb_rsp_err_i;

    modport master (
        output icb_cmd_valid_o, icb_cmd_addr_o, icb_cmd_read_o,
               icb_cmd_wdata_o, icb_cmd_wmask_o, icb_rsp_ready_o,
        input  icb_cmd_ready_i, icb_rsp_valid_i, icb_rsp_rdata_i, icb_rsp_err_i
    );

    modport slave (
        input  icb_cmd_valid_o, icb_cmd_addr_o, icb_cmd_read_o,
               icb_cmd_wdata_o, icb_cmd_wmask_o, icb_rsp_ready_o,
        output icb_cmd_ready_i, icb_rsp_valid_i, icb_rsp_rdata_i, icb_rsp_err_i
    );
endinterface

// File: rtl/dma_icb_rd_master.sv
// ---------------------------------------------------------------------------
// dma_icb_rd_master
// Reads len_i consecutive words starting at src_addr_i over ICB and streams
// them out through a DEPTH-entry FIFO.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start_i               : one-cycle transfer request (IDLE only)
//   src_addr_i, len_i     : start address / word count, captured with start_i
//   busy_o, done_o, err_o : status (done_o one-cycle, err_o sticky)
//   icb                   : ICB master port (see dma_icb_rd_master_if)
//   data_valid_o, data_ready_i, data_o : read-data stream (FIFO head)
// ---------------------------------------------------------------------------
`ifndef ICB_WIDTH
`define ICB_WIDTH 32
`endif

module dma_icb_rd_master #(
    parameter int DW    = `ICB_WIDTH,
    parameter int LW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [DW-1:0]       src_addr_i,
    input  logic [LW-1:0]       len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    dma_icb_rd_master_if.master icb,
    output logic                data_valid_o,
    input  logic                data_ready_i,
    output logic [DW-1:0]       data_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cmd_cnt_q, cmd_cnt_d;
    logic [LW-1:0] rsp_cnt_q, rsp_cnt_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;

    logic [LW:0]   inflight;
    logic          cmd_valid, cmd_hs, push, pop;

    // Credits in use: commands still awaiting a response plus words parked in
    // the FIFO. This sum never grows without a command handshake, so a
    // command valid derived from it cannot drop before it is accepted.
    assign inflight  = {1'b0, cmd_cnt_q - rsp_cnt_q} + (LW+1)'(cnt_q);
    assign cmd_valid = (state_q == RUN) && (cmd_cnt_q < len_q)
                       && (inflight < (LW+1)'(DEPTH));
    assign cmd_hs    = cmd_valid && icb.icb_cmd_ready_i;
    // Response ready is tied high; responses seen in IDLE are dropped.
    assign push      = icb.icb_rsp_valid_i && (state_q != IDLE);
    assign pop       = (cnt_q != '0) && data_ready_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cmd_cnt_d = cmd_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        err_d     = err_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (len_i != '0) begin
                        addr_d    = src_addr_i;
                        len_d     = len_i;
                        cmd_cnt_d = '0;
                        rsp_cnt_d = '0;
                        state_d   = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cmd_hs) begin
                    cmd_cnt_d = cmd_cnt_q + LW'(1);
                    addr_d    = addr_q + DW'(DW / 8);
                    if (cmd_cnt_q + LW'(1) == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((rsp_cnt_q == len_q) && (cnt_q == '0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            rsp_cnt_d = rsp_cnt_q + LW'(1);
            if (icb.icb_rsp_err_i) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cmd_cnt_q <= '0;
            rsp_cnt_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cmd_cnt_q <= cmd_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= icb.icb_rsp_rdata_i;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign data_valid_o = (cnt_q != '0);
    assign data_o       = mem_q[rptr_q];

    assign icb.icb_cmd_valid_o = cmd_valid;
    assign icb.icb_cmd_addr_o  = addr_q;
    assign icb.icb_cmd_read_o  = 1'b1;
    assign icb.icb_cmd_wdata_o = '0;
    assign icb.icb_cmd_wmask_o = '0;
    assign icb.icb_rsp_ready_o = 1'b1;

endmodule

// File: tb/tb_dma_icb_rd_master.sv
// ---------------------------------------------------------------------------
// tb_dma_icb_rd_master
// Directed and randomized transfers against dma_icb_rd_master. A word-per-
// address memory model answers ICB reads; the expected command addresses and
// output words of each transfer are precomputed from start address and length.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dma_icb_rd_master;

    localparam int DW    = 32;
    localparam int LW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [DW-1:0] src_addr_i;
    logic [LW-1:0] len_i;
    logic          busy_o, done_o, err_o;
    logic          data_valid_o, data_ready_i;
    logic [DW-1:0] data_o;

    dma_icb_rd_master_if #(.DW(DW)) icb ();

    dma_icb_rd_master #(.DW(DW), .LW(LW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .src_addr_i   (src_addr_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .icb          (icb),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .data_o       (data_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    logic [DW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [DW-1:0] pend_q[$];
    int cmd_total, pop_total, done_total, rsp_idx, err_idx;
    int p_cmd, p_rsp, p_dat;
    bit spurious;

    function automatic logic [DW-1:0] word_of(input logic [DW-1:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A17};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ICB slave + stream sink: inputs driven on the falling edge, handshakes
    // for the coming rising edge recorded 1ns later.
    initial begin
        logic          stall_q = 1'b0;
        logic [DW-1:0] stall_addr = '0;
        bit            real_rsp;
        icb.icb_cmd_ready_i = 1'b0;
        icb.icb_rsp_valid_i = 1'b0;
        icb.icb_rsp_rdata_i = '0;
        icb.icb_rsp_err_i   = 1'b0;
        data_ready_i        = 1'b0;
        forever begin
            @(negedge clk);
            real_rsp = 1'b0;
            if (!rst_n) begin
                icb.icb_cmd_ready_i = 1'b0;
                icb.icb_rsp_valid_i = 1'b0;
                icb.icb_rsp_err_i   = 1'b0;
                data_ready_i        = 1'b0;
                stall_q             = 1'b0;
            end else begin
                icb.icb_cmd_ready_i = ($urandom_range(99) < p_cmd);
                if (pend_q.size() > 0 && $urandom_range(99) < p_rsp) begin
                    icb.icb_rsp_valid_i = 1'b1;
                    icb.icb_rsp_rdata_i = word_of(pend_q[0]);
                    icb.icb_rsp_err_i   = (rsp_idx == err_idx);
                    real_rsp            = 1'b1;
                end else if (spurious && pend_q.size() == 0) begin
                    icb.icb_rsp_valid_i = 1'b1;
                    icb.icb_rsp_rdata_i = 32'hDEAD_BEEF;
                    icb.icb_rsp_err_i   = 1'b0;
                    spurious            = 1'b0;
                end else begin
                    icb.icb_rsp_valid_i = 1'b0;
                    icb.icb_rsp_rdata_i = '0;
                    icb.icb_rsp_err_i   = 1'b0;
                end
                data_ready_i = ($urandom_range(99) < p_dat);
                #1;
                if (stall_q) begin
                    check("cmd_hold_valid", icb.icb_cmd_valid_o, 1'b1);
                    check("cmd_hold_addr", icb.icb_cmd_addr_o, stall_addr);
                end
                stall_q    = icb.icb_cmd_valid_o && !icb.icb_cmd_ready_i;
                stall_addr = icb.icb_cmd_addr_o;
                if (icb.icb_cmd_valid_o && icb.icb_cmd_ready_i) begin
                    if (exp_addr_q.size() == 0) check("cmd_extra", 1, 0);
                    else check("cmd_addr", icb.icb_cmd_addr_o, exp_addr_q.pop_front());
                    pend_q.push_back(icb.icb_cmd_addr_o);
                    cmd_total++;
                end
                if (icb.icb_rsp_valid_i) begin
                    check("rsp_ready", icb.icb_rsp_ready_o, 1'b1);
                    if (real_rsp) begin
                        void'(pend_q.pop_front());
                        rsp_idx++;
                    end
                end
                if (data_valid_o && data_ready_i) begin
                    if (exp_data_q.size() == 0) check("data_extra", 1, 0);
                    else check("data", data_o, exp_data_q.pop_front());
                    pop_total++;
                end
                check("credit", (cmd_total - pop_total) <= DEPTH, 1);
                if (done_o) done_total++;
            end
        end
    end

    task automatic start_xfer(input logic [DW-1:0] a, input logic [LW-1:0] l);
        @(negedge clk); #2;
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int unsigned k = 0; k < l; k++) begin
            logic [DW-1:0] ak;
            ak = a + DW'(k * 4);
            exp_addr_q.push_back(ak);
            exp_data_q.push_back(word_of(ak));
        end
        cmd_total = 0; pop_total = 0; done_total = 0; rsp_idx = 0;
        start_i = 1'b1; src_addr_i = a; len_i = l;
        @(negedge clk); #2;
        start_i = 1'b0; src_addr_i = $urandom(); len_i = LW'($urandom());
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk); #2;
            seen = done_o;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
    endtask

    task automatic finish_checks(input string tag, input logic [LW-1:0] l, input bit exp_err);
        check({tag, "_err"}, err_o, exp_err);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_cmds"}, cmd_total, l);
        check({tag, "_words_left"}, exp_data_q.size(), 0);
        check({tag, "_pops"}, pop_total, l);
        @(negedge clk); #2;
        check({tag, "_done_pulse"}, done_o, 1'b0);
        check({tag, "_done_count"}, done_total, 1);
        check({tag, "_err_sticky"}, err_o, exp_err);
    endtask

    task automatic set_p(input int c, input int r, input int d);
        p_cmd = c; p_rsp = r; p_dat = d;
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [LW-1:0] rl;
        bit            hit;
        rst_n = 1'b0; start_i = 1'b0; src_addr_i = '0; len_i = '0;
        spurious = 1'b0; err_idx = -1; set_p(100, 100, 100);
        cmd_total = 0; pop_total = 0; done_total = 0; rsp_idx = 0;

        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_cmd_valid", icb.icb_cmd_valid_o, 1'b0);
        check("rst_data_valid", data_valid_o, 1'b0);
        check("rst_cmd_addr", icb.icb_cmd_addr_o, 32'h0);
        check("cmd_read", icb.icb_cmd_read_o, 1'b1);
        check("cmd_wdata", icb.icb_cmd_wdata_o, 32'h0);
        check("cmd_wmask", icb.icb_cmd_wmask_o, 4'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Basic 3-word read, first command one cycle after start
        start_xfer(32'h0000_1000, 3);
        check("latency_cmd_valid", icb.icb_cmd_valid_o, 1'b1);
        check("busy_run", busy_o, 1'b1);
        wait_done("basic");
        finish_checks("basic", 3, 1'b0);

        // Address wrap
        start_xfer(32'hFFFF_FFF8, 3);
        wait_done("wrap");
        finish_checks("wrap", 3, 1'b0);

        // Backpressure: credits limit commands to DEPTH
        set_p(100, 100, 0);
        start_xfer(32'h0000_2000, 8);
        repeat (20) @(negedge clk);
        #2;
        check("bp_cmds", cmd_total, DEPTH);
        check("bp_cmd_valid", icb.icb_cmd_valid_o, 1'b0);
        check("bp_data_valid", data_valid_o, 1'b1);
        check("bp_busy", busy_o, 1'b1);
        set_p(100, 100, 100);
        wait_done("bp");
        finish_checks("bp", 8, 1'b0);

        // Error on second response
        err_idx = 1;
        start_xfer(32'h0000_3000, 4);
        wait_done("rsp_err");
        finish_checks("rsp_err", 4, 1'b1);
        repeat (3) @(negedge clk);
        #2 check("err_hold_idle", err_o, 1'b1);
        err_idx = -1;

        // Zero length: done next cycle, no command, err cleared
        start_xfer(32'h0000_4000, 0);
        check("len0_done", done_o, 1'b1);
        check("len0_err_clear", err_o, 1'b0);
        check("len0_busy", busy_o, 1'b0);
        check("len0_cmds", cmd_total, 0);
        @(negedge clk); #2;
        check("len0_done_pulse", done_o, 1'b0);

        // start_i during RUN is ignored
        set_p(50, 60, 70);
        start_xfer(32'h0000_5000, 6);
        @(negedge clk); #2;
        start_i = 1'b1; src_addr_i = 32'h0000_6000; len_i = 2;
        @(negedge clk); #2;
        start_i = 1'b0;
        wait_done("ign_start");
        finish_checks("ign_start", 6, 1'b0);

        // Spurious response in IDLE is dropped
        spurious = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        check("spur_consumed", spurious, 1'b0);
        check("spur_data_valid", data_valid_o, 1'b0);
        check("spur_busy", busy_o, 1'b0);

        // Reset mid-transfer after 2 commands
        set_p(100, 100, 100);
        start_xfer(32'h0000_7000, 6);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk); #2;
            hit = (cmd_total >= 2);
        end
        check("mid_rst_reach2", cmd_total, 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_done", done_o, 1'b0);
        check("mid_rst_err", err_o, 1'b0);
        check("mid_rst_cmd_valid", icb.icb_cmd_valid_o, 1'b0);
        check("mid_rst_data_valid", data_valid_o, 1'b0);
        check("mid_rst_cmd_addr", icb.icb_cmd_addr_o, 32'h0);
        check("mid_rst_no_done", done_total, 0);
        pend_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        start_xfer(32'h0000_8000, 1);
        wait_done("post_rst");
        finish_checks("post_rst", 1, 1'b0);

        // Randomized transfers
        for (int t = 0; t < 8; t++) begin
            ra = $urandom() & 32'hFFFF_FFFC;
            if (t == 0) ra = 32'hFFFF_FFF0;
            rl = LW'($urandom_range(12, 1));
            err_idx = $urandom_range(15);
            set_p($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 30));
            start_xfer(ra, rl);
            check("rnd_err_cleared", err_o, 1'b0);
            wait_done("rnd");
            finish_checks("rnd", rl, err_idx < int'(rl));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
